// File: rtl/fetch_operand.sv
// MIX operand fetch: forms M = AA + rI in sign-magnitude, range-checks M and
// the field spec, reads memory and extracts field (L:R) as a right-aligned operand.
module fetch_operand #(
   parameter int MEMSIZE = 4000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [12:0] aa,
   input  logic [12:0] index,
   input  logic [5:0]  field,
   output logic        mem_rd,
   output logic [11:0] mem_addr,
   input  logic [30:0] mem_data,
   output logic [30:0] operand,
   output logic        done,
   output logic        error,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, ADDR, READ, WAIT, DONE} state_t;

   state_t      state;
   logic [12:0] aa_r;
   logic [12:0] idx_r;
   logic [5:0]  field_r;

   logic [12:0] ea_mag;
   logic        ea_neg;
   logic        addr_ok;
   logic        field_ok;

   // Bytes L'..R of the word, right-aligned; sign only survives when L = 0.
   function automatic logic [30:0] extract(input logic [30:0] w,
                                           input logic [2:0]  l,
                                           input logic [2:0]  r);
      logic [2:0]  lp;
      logic [29:0] mag;
      logic [29:0] mask;
      int          shi;
      int          widi;
      lp   = (l == 3'd0) ? 3'd1 : l;
      shi  = 6 * (5 - int'(r));
      widi = (r >= lp) ? 6 * (int'(r) - int'(lp) + 1) : 0;
      mask = 30'((31'd1 << widi) - 31'd1);
      mag  = (w[29:0] >> shi) & mask;
      return {(l == 3'd0) ? w[30] : 1'b0, mag};
   endfunction

   always_comb begin
      ea_mag = '0;
      ea_neg = 1'b0;
      if (aa_r[12] == idx_r[12]) begin
         ea_mag = {1'b0, aa_r[11:0]} + {1'b0, idx_r[11:0]};
         ea_neg = aa_r[12];
      end else if (aa_r[11:0] >= idx_r[11:0]) begin
         ea_mag = {1'b0, aa_r[11:0] - idx_r[11:0]};
         ea_neg = aa_r[12];
      end else begin
         ea_mag = {1'b0, idx_r[11:0] - aa_r[11:0]};
         ea_neg = idx_r[12];
      end
      if (ea_mag == 13'd0) ea_neg = 1'b0;
      addr_ok  = !ea_neg && (int'(ea_mag) < MEMSIZE);
      field_ok = (field_r[5:3] <= field_r[2:0]) && (field_r[2:0] <= 3'd5);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         aa_r     <= '0;
         idx_r    <= '0;
         field_r  <= '0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         operand  <= '0;
         error    <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  aa_r    <= aa;
                  idx_r   <= index;
                  field_r <= field;
                  operand <= '0;
                  error   <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ADDR;
               end
            end
            // ADDR -> READ on a legal request, straight to DONE otherwise
            ADDR: begin
               if (addr_ok && field_ok) begin
                  mem_rd   <= 1'b1;
                  mem_addr <= ea_mag[11:0];
                  state    <= READ;
               end else begin
                  error   <= 1'b1;
                  operand <= '0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            READ: begin
               mem_rd <= 1'b0;
               state  <= WAIT;
            end
            // WAIT: RAM data is valid the cycle after the strobe
            WAIT: begin
               operand <= extract(mem_data, field_r[5:3], field_r[2:0]);
               error   <= 1'b0;
               done    <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_operand.sv
// Self-checking bench for fetch_operand: vector table, scoreboard queue and
// hand-written abort / held-start sequences against a synchronous RAM model.
module tb_fetch_operand;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [12:0] aa;
   logic [12:0] index;
   logic [5:0]  field;
   logic        mem_rd;
   logic [11:0] mem_addr;
   logic [30:0] mem_data;
   logic [30:0] operand;
   logic        done;
   logic        error;
   logic        busy;

   logic [30:0] mem [0:4095];

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [12:0] aa;
      logic [12:0] idx;
      logic [5:0]  f;
      logic [30:0] word;
      logic [30:0] op;
      logic        err;
      logic [11:0] addr;
   } vec_t;

   typedef struct {
      logic [30:0] op;
      logic        err;
      int          lat;
   } exp_t;

   vec_t vt [12];
   exp_t sb [$];

   fetch_operand #(.MEMSIZE(4000)) dut (
      .clk(clk), .rst(rst), .start(start), .aa(aa), .index(index),
      .field(field), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .operand(operand), .done(done),
      .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   task automatic do_fetch(input vec_t v, input string tag);
      exp_t        e;
      exp_t        got_e;
      logic        got = 1'b0;
      logic        saw_rd = 1'b0;
      logic        busy_bad = 1'b0;
      int          rd_cyc = 0;
      int          done_cyc = 0;
      logic [11:0] rd_addr = '0;
      logic [30:0] op_seen = '0;
      logic        err_seen = 1'b0;
      if (!v.err) mem[v.addr] = v.word;
      e.op  = v.op;
      e.err = v.err;
      e.lat = v.err ? 2 : 4;
      @(negedge clk);
      aa    = v.aa;
      index = v.idx;
      field = v.f;
      start = 1'b1;
      sb.push_back(e);
      for (int c = 1; c <= 10 && !got; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c <= e.lat && !busy) busy_bad = 1'b1;
         if (mem_rd && !saw_rd) begin
            saw_rd  = 1'b1;
            rd_cyc  = c;
            rd_addr = mem_addr;
         end
         if (done) begin
            got      = 1'b1;
            done_cyc = c;
            op_seen  = operand;
            err_seen = error;
         end
      end
      got_e = sb.pop_front();
      chk({tag, "_done_seen"}, 64'(got), 64'd1);
      chk({tag, "_latency"}, 64'(done_cyc), 64'(got_e.lat));
      chk({tag, "_operand"}, 64'(op_seen), 64'(got_e.op));
      chk({tag, "_error"}, 64'(err_seen), 64'(got_e.err));
      chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
      if (got_e.err) begin
         chk({tag, "_no_read"}, 64'(saw_rd), 64'd0);
      end else begin
         chk({tag, "_rd_cycle"}, 64'(rd_cyc), 64'd2);
         chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(v.addr));
      end
      @(negedge clk);
      chk({tag, "_after_done"}, {62'd0, done, busy}, 64'd0);
      chk({tag, "_hold"}, {32'd0, error, operand}, {32'd0, got_e.err, got_e.op});
   endtask

   initial begin
      int dones;
      int rds;
      vt[0]  = '{13'd100,   13'd0,     6'd5,  31'h6AAAAAAA, 31'h6AAAAAAA, 1'b0, 12'd100};
      vt[1]  = '{13'd50,    13'd50,    6'd11, 31'h01083105, 31'd4227,     1'b0, 12'd100};
      vt[2]  = '{13'd7,     13'd0,     6'd0,  31'h7FFFFFFF, 31'h40000000, 1'b0, 12'd7};
      vt[3]  = '{13'd10,    13'h1014,  6'd5,  31'd0,        31'd0,        1'b1, 12'd0};
      vt[4]  = '{13'd5,     13'd0,     6'd26, 31'd0,        31'd0,        1'b1, 12'd0};
      vt[5]  = '{13'd5,     13'd0,     6'd6,  31'd0,        31'd0,        1'b1, 12'd0};
      vt[6]  = '{13'd3990,  13'd10,    6'd5,  31'd0,        31'd0,        1'b1, 12'd0};
      vt[7]  = '{13'h1005,  13'd5,     6'd5,  31'h00000ABC, 31'h00000ABC, 1'b0, 12'd0};
      vt[8]  = '{13'd3990,  13'd9,     6'd45, 31'h40000027, 31'h00000027, 1'b0, 12'd3999};
      vt[9]  = '{13'h1064,  13'd300,   6'd2,  31'h7FFFFFFF, 31'h40000FFF, 1'b0, 12'd200};
      vt[10] = '{13'h1001,  13'd0,     6'd5,  31'd0,        31'd0,        1'b1, 12'd0};
      vt[11] = '{13'h0FFF,  13'h1060,  6'd5,  31'h12345678, 31'h12345678, 1'b0, 12'd3999};

      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem_data = '0;
      rst   = 1'b1;
      start = 1'b0;
      aa    = '0;
      index = '0;
      field = '0;
      repeat (2) @(negedge clk);
      chk("rst_operand", 64'(operand), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_rd", 64'(mem_rd), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) do_fetch(vt[i], $sformatf("vec%0d", i));

      // Abort: reset asserted while the read strobe is high.
      mem[100] = 31'h6AAAAAAA;
      @(negedge clk);
      aa = 13'd100; index = '0; field = 6'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort_rd_high", 64'(mem_rd), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort_outputs_zero", {18'd0, operand, error, done, busy, mem_rd, mem_addr}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("abort_no_done", 64'(dones), 64'd0);
      do_fetch(vt[1], "retrigger");

      // Start held through the busy window must not launch a second fetch.
      mem[7] = 31'h7FFFFFFF;
      @(negedge clk);
      aa = 13'd7; index = '0; field = 6'd0; start = 1'b1;
      dones = 0;
      rds   = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 5) start = 1'b0;
         if (done) dones++;
         if (mem_rd) rds++;
      end
      chk("held_start_dones", 64'(dones), 64'd1);
      chk("held_start_reads", 64'(rds), 64'd1);
      chk("held_start_operand", 64'(operand), 64'h40000000);
      chk("held_start_idle", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
